// File: rtl/l1_pkg.sv
// Shared types and defaults for the L1 load-data memory controller.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
// Contents: default geometry, refill FIFO entry layout {addr, data}.
package l1_pkg;

   localparam int L1_LD_WIDTH    = 32;
   localparam int L1_LD_DEPTH    = 1024;
   localparam int L1_LD_AW       = $clog2(L1_LD_DEPTH);
   localparam int L1_LD_FQ_DEPTH = 2;

   // Refill FIFO entry for the default geometry; address sits above data.
   typedef struct packed {
      logic [L1_LD_AW-1:0]    addr;
      logic [L1_LD_WIDTH-1:0] data;
   } l1_ld_fill_t;

   localparam int L1_LD_FILL_W = $bits(l1_ld_fill_t);

endpackage

// File: rtl/l1_ld_fill_fifo.sv
// Synchronous FIFO holding refill writes, with every slot exposed for address compare.
// Latency: 1 cycle push-to-head; head is combinational from storage.
// Backpressure: push ignored when full, pop ignored when empty; caller gates with full/empty.
// Ports: clk/rst_n; push/push_dat; pop; head, full, empty, count, rd_ptr, entries (slot i at [i*EW +: EW]).
module l1_ld_fill_fifo
   import l1_pkg::*;
#(
   parameter int  EW    = L1_LD_FILL_W,
   parameter int  DEPTH = L1_LD_FQ_DEPTH,
   localparam int PW    = $clog2(DEPTH),
   localparam int CW    = PW + 1
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                push,
   input  logic [EW-1:0]       push_dat,
   input  logic                pop,
   output logic [EW-1:0]       head,
   output logic                full,
   output logic                empty,
   output logic [CW-1:0]       count,
   output logic [PW-1:0]       rd_ptr,
   output logic [DEPTH*EW-1:0] entries
);

   logic [EW-1:0] mem [DEPTH];
   logic [PW-1:0] wr_ptr;
   logic          do_push;
   logic          do_pop;

   assign full    = (count == CW'(DEPTH));
   assign empty   = (count == '0);
   assign do_push = push & ~full;
   assign do_pop  = pop & ~empty;
   assign head    = mem[rd_ptr];

   for (genvar i = 0; i < DEPTH; i++) begin : g_flat
      assign entries[i*EW +: EW] = mem[i];
   end

   // DEPTH is a power of two, so the pointers wrap naturally.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
         for (int i = 0; i < DEPTH; i++) begin
            mem[i] <= '0;
         end
      end else begin
         if (do_push) begin
            mem[wr_ptr] <= push_dat;
            wr_ptr      <= wr_ptr + 1'b1;
         end
         if (do_pop) begin
            rd_ptr <= rd_ptr + 1'b1;
         end
         if (do_push && !do_pop) begin
            count <= count + 1'b1;
         end else if (do_pop && !do_push) begin
            count <= count - 1'b1;
         end
      end
   end

endmodule

// File: rtl/l1_ld_mem_ctrl.sv
// Access controller in front of the L1 load-data dual-port memory wrapper, with refill write forwarding.
// Latency: read response 1 cycle after acceptance; refill written at the earliest 1 cycle after acceptance.
// Backpressure: req_rdy/fill_rdy low until the wrapper is ready; fill_rdy also low when the refill FIFO is full; no response backpressure.
// Ports: CLK/RST_N; core read req_*/resp_*; refill fill_*; wrapper mem_* read port, write port and mem_ready.
module l1_ld_mem_ctrl
   import l1_pkg::*;
#(
   parameter int  WIDTH    = L1_LD_WIDTH,
   parameter int  DEPTH    = L1_LD_DEPTH,
   parameter int  FQ_DEPTH = L1_LD_FQ_DEPTH,
   localparam int AW       = $clog2(DEPTH)
) (
   input  logic             CLK,
   input  logic             RST_N,
   input  logic             req_val,
   input  logic [AW-1:0]    req_addr,
   output logic             req_rdy,
   output logic             resp_val,
   output logic [WIDTH-1:0] resp_data,
   input  logic             fill_val,
   input  logic [AW-1:0]    fill_addr,
   input  logic [WIDTH-1:0] fill_data,
   output logic             fill_rdy,
   output logic             mem_ren,
   output logic [AW-1:0]    mem_raddr,
   input  logic [WIDTH-1:0] mem_rdata,
   output logic             mem_wen,
   output logic [AW-1:0]    mem_waddr,
   output logic [WIDTH-1:0] mem_wdata,
   input  logic             mem_ready
);

   localparam int PW = $clog2(FQ_DEPTH);
   localparam int CW = PW + 1;

   typedef struct packed {
      logic [AW-1:0]    addr;
      logic [WIDTH-1:0] data;
   } fill_t;

   localparam int EW = $bits(fill_t);

   // run is cleared asynchronously so every grant drops the instant RST_N falls,
   // regardless of what the wrapper is still reporting on mem_ready.
   logic                  run;
   logic                  live;
   logic                  accept;
   logic                  push;
   logic                  pop;
   fill_t                 push_ent;
   fill_t                 head;
   logic                  full;
   logic                  empty;
   logic [CW-1:0]         count;
   logic [PW-1:0]         rd_ptr;
   logic [FQ_DEPTH*EW-1:0] entries;

   logic                  fwd_hit_d;
   logic [WIDTH-1:0]      fwd_data_d;
   logic [PW-1:0]         slot;
   fill_t                 ent;
   logic                  fwd_hit;
   logic [WIDTH-1:0]      fwd_data;
   logic [WIDTH-1:0]      hold_data;

   assign live     = run & mem_ready;
   assign req_rdy  = live;
   assign fill_rdy = live & ~full;
   assign accept   = req_val & req_rdy;
   assign push     = fill_val & fill_rdy;
   assign pop      = live & ~empty;
   assign push_ent = '{addr: fill_addr, data: fill_data};

   assign mem_ren   = accept;
   assign mem_raddr = accept ? req_addr : '0;
   assign mem_wen   = pop;
   assign mem_waddr = pop ? head.addr : '0;
   assign mem_wdata = pop ? head.data : '0;

   l1_ld_fill_fifo #(
      .EW    (EW),
      .DEPTH (FQ_DEPTH)
   ) u_fill_fifo (
      .clk      (CLK),
      .rst_n    (RST_N),
      .push     (push),
      .push_dat (push_ent),
      .pop      (pop),
      .head     (head),
      .full     (full),
      .empty    (empty),
      .count    (count),
      .rd_ptr   (rd_ptr),
      .entries  (entries)
   );

   // Walk occupied slots oldest to youngest so the last match is the youngest.
   // The head counts even while it is being written: the SRAM read issued this
   // cycle cannot see that write. A fill pushed this cycle is not yet in the FIFO,
   // and by the time it could matter it has been written or is the head.
   always_comb begin
      fwd_hit_d  = 1'b0;
      fwd_data_d = '0;
      slot       = '0;
      ent        = '0;
      for (int k = 0; k < FQ_DEPTH; k++) begin
         slot = rd_ptr + PW'(k);
         ent  = entries[slot*EW +: EW];
         if ((CW'(k) < count) && (ent.addr == req_addr)) begin
            fwd_hit_d  = 1'b1;
            fwd_data_d = ent.data;
         end
      end
   end

   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         run       <= 1'b0;
         resp_val  <= 1'b0;
         fwd_hit   <= 1'b0;
         fwd_data  <= '0;
         hold_data <= '0;
      end else begin
         run      <= 1'b1;
         resp_val <= accept;
         fwd_hit  <= accept & fwd_hit_d;
         fwd_data <= fwd_data_d;
         if (resp_val) begin
            hold_data <= resp_data;
         end
      end
   end

   // mem_rdata is only meaningful the cycle after mem_ren; otherwise replay the last response.
   assign resp_data = !resp_val ? hold_data :
                      fwd_hit   ? fwd_data  : mem_rdata;

endmodule

// File: tb/tb_l1_ld_mem_ctrl.sv
// Self-checking bench for l1_ld_mem_ctrl with a behavioural dual-port wrapper model.
// Latency: n/a.
// Backpressure: n/a.
module tb_l1_ld_mem_ctrl;
   import l1_pkg::*;

   localparam int WIDTH = 32;
   localparam int DEPTH = 1024;
   localparam int AW    = 10;
   localparam int FQ    = 2;

   logic             CLK = 1'b0;
   logic             RST_N;
   logic             req_val;
   logic [AW-1:0]    req_addr;
   logic             req_rdy;
   logic             resp_val;
   logic [WIDTH-1:0] resp_data;
   logic             fill_val;
   logic [AW-1:0]    fill_addr;
   logic [WIDTH-1:0] fill_data;
   logic             fill_rdy;
   logic             mem_ren;
   logic [AW-1:0]    mem_raddr;
   logic [WIDTH-1:0] mem_rdata;
   logic             mem_wen;
   logic [AW-1:0]    mem_waddr;
   logic [WIDTH-1:0] mem_wdata;
   logic             mem_ready;

   int vectors     = 0;
   int miscompares = 0;
   int cyc         = 0;

   typedef struct {
      logic [WIDTH-1:0] data;
      int               due;
   } resp_exp_t;

   resp_exp_t        rq[$];
   l1_ld_fill_t      wq[$];
   logic [WIDTH-1:0] mem    [DEPTH];
   logic [WIDTH-1:0] shadow [DEPTH];
   logic [WIDTH-1:0] mem_rd_tmp;

   l1_ld_mem_ctrl #(.WIDTH(WIDTH), .DEPTH(DEPTH), .FQ_DEPTH(FQ)) dut (
      .CLK       (CLK),
      .RST_N     (RST_N),
      .req_val   (req_val),
      .req_addr  (req_addr),
      .req_rdy   (req_rdy),
      .resp_val  (resp_val),
      .resp_data (resp_data),
      .fill_val  (fill_val),
      .fill_addr (fill_addr),
      .fill_data (fill_data),
      .fill_rdy  (fill_rdy),
      .mem_ren   (mem_ren),
      .mem_raddr (mem_raddr),
      .mem_rdata (mem_rdata),
      .mem_wen   (mem_wen),
      .mem_waddr (mem_waddr),
      .mem_wdata (mem_wdata),
      .mem_ready (mem_ready)
   );

   always #5 CLK = ~CLK;

   // Wrapper model: read data registered one cycle after REN, read-before-write on a collision.
   initial begin
      for (int i = 0; i < DEPTH; i++) mem[i] = WIDTH'(i + 'h100);
      mem_rdata = '0;
      forever begin
         @(posedge CLK);
         mem_rd_tmp = mem_rdata;
         if (mem_ren) mem_rd_tmp = mem[mem_raddr];
         if (mem_wen) mem[mem_waddr] = mem_wdata;
         mem_rdata <= mem_rd_tmp;
      end
   end

   // Scoreboard: shadow is the architectural memory (a fill is visible from the cycle after acceptance).
   initial begin
      resp_exp_t   e;
      l1_ld_fill_t f;
      forever begin
         @(negedge CLK);
         cyc++;
         if (!RST_N) begin
            rq.delete();
            wq.delete();
            for (int i = 0; i < DEPTH; i++) shadow[i] = mem[i];
         end else begin
            while (rq.size() > 0 && rq[0].due < cyc) begin
               e = rq.pop_front();
               vectors++; miscompares++;
               $display("FAIL resp_missing: cyc=%0d no resp_val, want data %h due cyc %0d", cyc, e.data, e.due);
            end
            if (resp_val) begin
               vectors++;
               if (rq.size() == 0) begin
                  miscompares++;
                  $display("FAIL resp_unexpected: cyc=%0d resp_val=1 data=%h, want no response", cyc, resp_data);
               end else begin
                  e = rq.pop_front();
                  if (resp_data !== e.data || e.due != cyc) begin
                     miscompares++;
                     $display("FAIL resp_data: cyc=%0d got %h, want %h (due cyc %0d)", cyc, resp_data, e.data, e.due);
                  end
               end
            end
            if (mem_wen) begin
               vectors++;
               if (wq.size() == 0) begin
                  miscompares++;
                  $display("FAIL write_unexpected: cyc=%0d waddr=%h wdata=%h", cyc, mem_waddr, mem_wdata);
               end else begin
                  f = wq.pop_front();
                  if ({mem_waddr, mem_wdata} !== f) begin
                     miscompares++;
                     $display("FAIL write_order: cyc=%0d got %h/%h, want %h/%h", cyc, mem_waddr, mem_wdata, f.addr, f.data);
                  end
               end
            end
            if (req_val && req_rdy) rq.push_back('{data: shadow[req_addr], due: cyc + 1});
            if (fill_val && fill_rdy) begin
               wq.push_back('{addr: fill_addr, data: fill_data});
               shadow[fill_addr] = fill_data;
            end
         end
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog expired");
   end

   task automatic step();
      @(posedge CLK);
      #1;
   endtask

   task automatic test_reset();
      RST_N = 1'b0; mem_ready = 1'b1;
      req_val = 1'b1; req_addr = 10'h003;
      fill_val = 1'b1; fill_addr = 10'h003; fill_data = 32'h1;
      #1;
      vectors++;
      if ({req_rdy, fill_rdy, resp_val, mem_ren, mem_wen} !== 5'b0) begin
         miscompares++;
         $display("FAIL reset_ctrl: got rdy/frdy/rval/ren/wen=%b, want 00000", {req_rdy, fill_rdy, resp_val, mem_ren, mem_wen});
      end
      vectors++;
      if (resp_data !== '0) begin
         miscompares++;
         $display("FAIL reset_resp_data: got %h, want 0", resp_data);
      end
      vectors++;
      if ({mem_raddr, mem_waddr, mem_wdata} !== '0) begin
         miscompares++;
         $display("FAIL reset_mem_bus: got raddr=%h waddr=%h wdata=%h, want 0", mem_raddr, mem_waddr, mem_wdata);
      end
      repeat (2) @(negedge CLK);
      step();
      req_val = 1'b0; fill_val = 1'b0; mem_ready = 1'b0; RST_N = 1'b1;
   endtask

   task automatic test_init_hold();
      req_val = 1'b1; req_addr = 10'h005;
      fill_val = 1'b1; fill_addr = 10'h005; fill_data = 32'hA5A5_0005;
      for (int i = 0; i < 1024; i++) begin
         step();
         @(negedge CLK);
         vectors++;
         if ({req_rdy, fill_rdy, mem_ren, mem_wen} !== 4'b0) begin
            miscompares++;
            $display("FAIL init_hold: cycle %0d got rdy/frdy/ren/wen=%b, want 0000", i, {req_rdy, fill_rdy, mem_ren, mem_wen});
         end
      end
      step();
      mem_ready = 1'b1;
      @(negedge CLK);
      vectors++;
      if ({req_rdy, fill_rdy, mem_ren} !== 3'b111 || mem_raddr !== 10'h005) begin
         miscompares++;
         $display("FAIL init_first_grant: got rdy/frdy/ren=%b raddr=%h, want 111 005", {req_rdy, fill_rdy, mem_ren}, mem_raddr);
      end
      step();
      req_val = 1'b0; fill_val = 1'b0;
      @(negedge CLK);
      vectors++;
      if (resp_val !== 1'b1 || resp_data !== 32'h105) begin
         miscompares++;
         $display("FAIL init_same_cycle_fill: got val=%b data=%h, want 1 00000105", resp_val, resp_data);
      end
      step();
   endtask

   task automatic test_back_to_back();
      for (int i = 0; i < 4; i++) begin
         step();
         req_val  = (i < 3);
         req_addr = AW'(10'h010 + i);
         @(negedge CLK);
         if (i > 0) begin
            vectors++;
            if (resp_val !== 1'b1 || resp_data !== WIDTH'(32'h10F + i)) begin
               miscompares++;
               $display("FAIL b2b_resp%0d: got val=%b data=%h, want 1 %h", i, resp_val, resp_data, 32'h10F + i);
            end
         end
      end
      step();
      @(negedge CLK);
      vectors++;
      if (resp_val !== 1'b0) begin
         miscompares++;
         $display("FAIL b2b_idle: got resp_val=%b, want 0", resp_val);
      end
   endtask

   task automatic test_same_cycle_fill();
      step();
      req_val = 1'b1; req_addr = 10'h040;
      fill_val = 1'b1; fill_addr = 10'h040; fill_data = 32'hCAFE_F00D;
      step();
      fill_val = 1'b0;
      @(negedge CLK);
      vectors++;
      if (resp_data !== 32'h140 || mem_wen !== 1'b1 || mem_waddr !== 10'h040) begin
         miscompares++;
         $display("FAIL same_cycle_no_fwd: got data=%h wen=%b waddr=%h, want 00000140 1 040", resp_data, mem_wen, mem_waddr);
      end
      step();
      req_val = 1'b0;
      @(negedge CLK);
      vectors++;
      if (resp_data !== 32'hCAFE_F00D) begin
         miscompares++;
         $display("FAIL head_fwd: got %h, want cafef00d", resp_data);
      end
      step();
      @(negedge CLK);
      vectors++;
      if (resp_val !== 1'b0 || resp_data !== 32'hCAFE_F00D) begin
         miscompares++;
         $display("FAIL resp_hold: got val=%b data=%h, want 0 cafef00d", resp_val, resp_data);
      end
   endtask

   task automatic test_fill_then_read();
      int wens = 0;
      for (int c = 0; c < 8; c++) begin
         step();
         fill_val = (c == 0); fill_addr = 10'h020; fill_data = 32'hDEAD_BEEF;
         req_val = (c == 1 || c == 5); req_addr = 10'h020;
         @(negedge CLK);
         if (mem_wen && mem_waddr == 10'h020) wens++;
         if (c == 2 || c == 6) begin
            vectors++;
            if (resp_val !== 1'b1 || resp_data !== 32'hDEAD_BEEF) begin
               miscompares++;
               $display("FAIL fill_read_c%0d: got val=%b data=%h, want 1 deadbeef", c, resp_val, resp_data);
            end
         end
      end
      vectors++;
      if (wens != 1) begin
         miscompares++;
         $display("FAIL fill_wen_count: got %0d writes to 020, want 1", wens);
      end
   endtask

   task automatic test_youngest();
      for (int c = 0; c < 6; c++) begin
         step();
         fill_val = (c < 2); fill_addr = 10'h030; fill_data = (c == 0) ? 32'h1 : 32'h2;
         mem_ready = !(c == 2 || c == 3);
         req_val = (c == 4); req_addr = 10'h030;
         @(negedge CLK);
         if (c == 3) begin
            vectors++;
            if (mem_wen !== 1'b0 || fill_rdy !== 1'b0) begin
               miscompares++;
               $display("FAIL youngest_stall: got wen=%b fill_rdy=%b, want 0 0", mem_wen, fill_rdy);
            end
         end
         if (c == 5) begin
            vectors++;
            if (resp_val !== 1'b1 || resp_data !== 32'h2) begin
               miscompares++;
               $display("FAIL youngest_fwd: got val=%b data=%h, want 1 00000002", resp_val, resp_data);
            end
         end
      end
   endtask

   task automatic test_full_backpressure();
      for (int c = 0; c < 7; c++) begin
         step();
         fill_val = (c < 5); fill_addr = AW'(10'h070 + (c > 2 ? 2 : c));
         fill_data = WIDTH'(32'h700 + (c > 2 ? 2 : c));
         mem_ready = !(c == 2 || c == 3);
         @(negedge CLK);
         if (c == 2 || c == 3) begin
            vectors++;
            if (fill_rdy !== 1'b0 || mem_wen !== 1'b0) begin
               miscompares++;
               $display("FAIL full_hold_c%0d: got fill_rdy=%b wen=%b, want 0 0", c, fill_rdy, mem_wen);
            end
         end
         if (c == 4) begin
            vectors++;
            if (fill_rdy !== 1'b1 || mem_wen !== 1'b1 || mem_waddr !== 10'h071) begin
               miscompares++;
               $display("FAIL full_release: got fill_rdy=%b wen=%b waddr=%h, want 1 1 071", fill_rdy, mem_wen, mem_waddr);
            end
         end
      end
   endtask

   task automatic test_async_reset();
      step();
      req_val = 1'b1; req_addr = 10'h050;
      fill_val = 1'b1; fill_addr = 10'h060; fill_data = 32'h0000_600D;
      step();
      req_val = 1'b0; fill_val = 1'b0;
      RST_N = 1'b0;
      #1;
      vectors++;
      if ({req_rdy, fill_rdy, resp_val, mem_ren, mem_wen} !== 5'b0 || resp_data !== '0) begin
         miscompares++;
         $display("FAIL async_reset_ctrl: got rdy/frdy/rval/ren/wen=%b data=%h, want 00000 0",
                  {req_rdy, fill_rdy, resp_val, mem_ren, mem_wen}, resp_data);
      end
      vectors++;
      if ({mem_raddr, mem_waddr, mem_wdata} !== '0) begin
         miscompares++;
         $display("FAIL async_reset_bus: got raddr=%h waddr=%h wdata=%h, want 0", mem_raddr, mem_waddr, mem_wdata);
      end
      @(negedge CLK);
      step();
      RST_N = 1'b1;
      step();
      step();
      req_val = 1'b1; req_addr = 10'h060;
      step();
      req_val = 1'b0;
      @(negedge CLK);
      vectors++;
      if (resp_val !== 1'b1 || resp_data !== 32'h160) begin
         miscompares++;
         $display("FAIL async_reset_fifo_dropped: got val=%b data=%h, want 1 00000160", resp_val, resp_data);
      end
   endtask

   initial begin
      RST_N = 1'b0; mem_ready = 1'b0;
      req_val = 1'b0; req_addr = '0;
      fill_val = 1'b0; fill_addr = '0; fill_data = '0;
      test_reset();
      test_init_hold();
      test_back_to_back();
      test_same_cycle_fill();
      test_fill_then_read();
      test_youngest();
      test_full_backpressure();
      test_async_reset();
      repeat (4) step();
      @(negedge CLK);
      vectors++;
      if (rq.size() != 0 || wq.size() != 0) begin
         miscompares++;
         $display("FAIL drain: got %0d reads and %0d writes outstanding, want 0 0", rq.size(), wq.size());
      end
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
